// File: rtl/inst_fetch_unit_if.sv
// Bundles the instruction-memory, redirect and decode-side signals of the fetch stage.
// The master modport is the fetch unit; the slave modport is the memory/decode environment.
interface inst_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_instr;
  logic [PC_WIDTH-1:0] id_pc;
  logic [PC_WIDTH-1:0] id_pc_plus4;
  logic [5:0]          id_op;
  logic [5:0]          id_funct;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr, id_pc, id_pc_plus4, id_op, id_funct
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr, id_pc, id_pc_plus4, id_op, id_funct
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, registered instruction to decode,
// redirect from later stages with squashing of the in-flight response.
module inst_fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 4
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                squash_q, squash_d;
  logic                id_valid_q, id_valid_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [PC_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [PC_WIDTH-1:0] pc_next_seq;

  assign pc_next_seq = pc_q + PC_WIDTH'(PC_STEP);

  // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (bus.redirect) pc_d = bus.redirect_pc;
      end

      S_FETCH: begin
        if (bus.imem_gnt) state_d = S_WAIT;
        // The granted read targets the old PC, so a coincident redirect must squash it.
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_gnt) squash_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = S_FETCH;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_FETCH;
          end else begin
            id_instr_d    = bus.imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_next_seq;
            id_valid_d    = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // A redirect alongside id_ready still completes the handshake; only the next PC differs.
        if (bus.redirect) begin
          pc_d       = bus.redirect_pc;
          id_valid_d = 1'b0;
          state_d    = S_FETCH;
        end else if (bus.id_ready) begin
          pc_d       = pc_next_seq;
          id_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_op       = id_instr_q[31:26];
  assign bus.id_funct    = id_instr_q[5:0];

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the main control decoder.
- Holds the PC and issues one instruction-memory read at a time.
- Registers the returned instruction and presents it, with its PC, to decode over a valid/ready handshake.
- Supplies the decoder's OP and funct fields pre-sliced; accepts a branch/jump redirect from later stages.

Parameters:
- PC_WIDTH, 32, width of PC, memory address and redirect target.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  PC_WIDTH  read address; equals the PC register.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  PC_WIDTH  target PC when redirect=1.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes the instruction this cycle.
- id_instr  out  32  registered instruction.
- id_pc  out  PC_WIDTH  address of id_instr.
- id_pc_plus4  out  PC_WIDTH  id_pc + PC_STEP.
- id_op  out  6  id_instr[31:26].
- id_funct  out  6  id_instr[5:0].

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, squash=0.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, imem_req=0.
- States:
  - IDLE: imem_req=0; always moves to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc, held stable until imem_gnt. On gnt -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid: id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc+PC_STEP, id_valid<=1 -> HOLD.
  - HOLD: id_valid=1; id_instr, id_pc and id_pc_plus4 held stable. On id_ready: id_valid<=0, pc<=pc+PC_STEP -> FETCH.
- Only one request is ever outstanding; imem_rvalid outside WAIT is ignored.
- Minimum latency from gnt to id_valid=1 is 2 cycles: rvalid no earlier than the cycle after gnt, then the registered output.
- Back-to-back throughput is one instruction per 3 cycles.
- PC arithmetic is modulo 2^PC_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.
- id_op and id_funct are pure slices of id_instr.
- Redirect has priority over every other event in the same cycle:
  - IDLE: pc<=redirect_pc; IDLE -> FETCH still happens.
  - FETCH without gnt: pc<=redirect_pc, stay FETCH. The next cycle presents the new address.
  - FETCH with gnt in the same cycle: pc<=redirect_pc, squash<=1 -> WAIT.
  - WAIT: pc<=redirect_pc, squash<=1. If rvalid arrives the same cycle, the data is discarded, squash<=0 -> FETCH.
  - HOLD: pc<=redirect_pc, id_valid<=0 -> FETCH. If id_ready was also high, that handshake counts as completed; the instruction is delivered and the PC still takes redirect_pc.
- Squashed responses:
  - With squash=1, rvalid in WAIT discards the data, clears squash -> FETCH at the already-updated pc.
  - A squashed response never raises id_valid.
- Reset asserted mid-operation overrides redirect and handshakes; state returns to IDLE with reset values.
- A response still in flight from before reset is ignored, because the unit is not in WAIT when it arrives.

Test Plan:
- Reset then basic fetch:
  - Stimulus: rst_n low 2 cycles, release; memory grants immediately, rvalid 1 cycle later with 32'h0000_0020, id_ready=1.
  - Response: imem_addr=0 in FETCH; id_valid with id_pc=0, id_op=0, id_funct=6'h20, id_pc_plus4=4; next request at addr 4.
- Decode stall:
  - Stimulus: id_ready=0 for 5 cycles while an instruction is held.
  - Response: id_valid stays 1 and id_instr stays stable; imem_req=0 throughout; release -> next fetch at pc+4.
- Redirect in WAIT with late memory:
  - Stimulus: fetch addr 8 granted; redirect to 32'h100 in WAIT; rvalid 3 cycles later with 32'h8C01_0004.
  - Response: data discarded and id_valid never 1; next imem_addr=32'h100.
- Redirect coinciding with gnt:
  - Stimulus: redirect to 32'h40 in the same cycle as imem_gnt.
  - Response: the following response is dropped; next request at 32'h40.
- Redirect in HOLD together with id_ready:
  - Response: handshake completes; id_valid=0 next cycle; next fetch at redirect_pc, not pc+4.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFFC, deliver the instruction.
  - Response: id_pc_plus4=0; next imem_addr=0.
